muldiv_sequencer: RTL and testbench

- Iterative multiply/divide engine with its control FSM. It executes UMUL/SMUL/UDIV/SDIV issued from the EX stage.
- It freezes the pipeline (STALL) while it owns the instruction in EX, then presents a 32-bit result, the Y high word or remainder, and integer condition codes for one cycle.
- Sits beside the ALU in EX. Its RESULT/flags are muxed ahead of the EX/MEM register and the PSR/ICC mux.

---
 rtl/muldiv_sequencer.sv | 110 +++++++++++
 tb/tb_muldiv_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiplier / restoring divider that stalls EX until its result is ready.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             kill,
    output logic             STALL,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] Y_OUT,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic             DZ
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
    state_t               r_state, w_next;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a, r_b, r_m;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH:0]       r_rem;
    logic [CW-1:0]        r_cnt;
    logic                 r_sq, r_sr;
    logic                 w_signed, w_div, w_dz, w_ovf;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_quo, w_rmd, w_res, w_y;
    logic [WIDTH:0]       w_sum, w_shift, w_diff;
    logic [2*WIDTH-1:0]   w_prod;
    assign w_signed = r_op[0];
    assign w_div    = r_op[1];
    assign w_abs_a  = (w_signed & r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_abs_b  = (w_signed & r_b[WIDTH-1]) ? -r_b : r_b;
    assign w_dz     = w_div & (r_b == '0);
    // Multiply keeps the multiplier in the low half of r_acc; divide keeps the dividend there and shifts quotient bits in.
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
    assign w_shift  = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_m};
    assign w_prod   = r_sq ? -r_acc : r_acc;
    assign w_quo    = r_sq ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rmd    = r_sr ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    assign w_ovf    = w_div & w_signed & (r_a == {1'b1, {(WIDTH-1){1'b0}}}) & (r_b == '1);
    assign w_res    = w_ovf ? {1'b0, {(WIDTH-1){1'b1}}} : w_div ? w_quo : w_prod[WIDTH-1:0];
    assign w_y      = w_ovf ? '0 : w_div ? w_rmd : w_prod[2*WIDTH-1:WIDTH];
    assign busy     = r_state != IDLE;
    assign done     = r_state == DONE;
    always_comb begin
        STALL = (r_state == IDLE) ? (start & ~kill) : (r_state != DONE);
        case (r_state)
            IDLE:    w_next = (start & ~kill) ? PREP : IDLE;
            PREP:    w_next = kill ? IDLE : w_dz ? DONE : RUN;
            RUN:     w_next = kill ? IDLE : (r_cnt == CW'(WIDTH-1)) ? FIX : RUN;
            FIX:     w_next = kill ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            RESULT  <= '0;
            Y_OUT   <= '0;
            {N, Z, V, C, DZ} <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == PREP) begin
                r_op <= op;
                r_a  <= A;
                r_b  <= B;
            end
            if (r_state == PREP) begin
                r_cnt <= '0;
                r_sq  <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                r_sr  <= w_signed & r_a[WIDTH-1];
                r_m   <= w_div ? w_abs_b : w_abs_a;
                r_acc <= {{WIDTH{1'b0}}, w_div ? w_abs_a : w_abs_b};
                r_rem <= '0;
                if (w_next == DONE) begin
                    RESULT <= '1;
                    Y_OUT  <= r_a;
                    {N, Z, V, C, DZ} <= 5'b10101;
                end
            end
            if (r_state == RUN) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_div) begin
                    r_rem             <= w_diff[WIDTH] ? w_shift : w_diff;
                    r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
                end else begin
                    r_acc <= r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
                end
            end
            if (r_state == FIX && w_next == DONE) begin
                RESULT <= w_res;
                Y_OUT  <= w_y;
                N      <= w_res[WIDTH-1];
                Z      <= w_res == '0;
                V      <= w_ovf;
                C      <= 1'b0;
                DZ     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with an arithmetic reference model checked on every done pulse.
module tb_muldiv_sequencer;
    logic        clk = 0, R, start, kill, STALL, busy, done, N, Z, V, C, DZ;
    logic [1:0]  op;
    logic [31:0] A, B, RESULT, Y_OUT;
    int          errs = 0, checks = 0, st, cnt;
    typedef struct packed {
        logic [31:0] r, y;
        logic        n, z, v, c, dz;
    } res_t;
    res_t exp_r;
    logic live = 0;
    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .R(R), .start(start), .op(op), .A(A), .B(B), .kill(kill),
        .STALL(STALL), .busy(busy), .done(done), .RESULT(RESULT), .Y_OUT(Y_OUT),
        .N(N), .Z(Z), .V(V), .C(C), .DZ(DZ)
    );
    always #5 clk = ~clk;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic res_t model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        res_t        e;
        logic [63:0] p;
        int          qs, rs;
        e = '0;
        if (o[1] && b == 0) begin
            e.r = '1; e.y = a; e.v = 1; e.dz = 1;
        end else if (o == 2'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            e.r = 32'h7FFFFFFF; e.y = 0; e.v = 1;
        end else if (o == 2'd0) begin
            p = {32'b0, a} * {32'b0, b};
            e.r = p[31:0]; e.y = p[63:32];
        end else if (o == 2'd1) begin
            p = longint'($signed(a)) * longint'($signed(b));
            e.r = p[31:0]; e.y = p[63:32];
        end else if (o == 2'd2) begin
            e.r = a / b; e.y = a % b;
        end else begin
            qs = $signed(a) / $signed(b);
            rs = $signed(a) % $signed(b);
            e.r = qs; e.y = rs;
        end
        e.n = e.r[31];
        e.z = e.r == 0;
        return e;
    endfunction
    always @(posedge clk) begin
        if (R) live <= 0;
        else if (!busy && start && !kill) begin
            live  <= 1;
            exp_r <= model(op, A, B);
        end else if (busy && (kill || done)) live <= 0;
    end
    always @(negedge clk) begin
        if (!R && done) begin
            chk("done_expected", live, 1);
            chk("model_result", RESULT, exp_r.r);
            chk("model_y", Y_OUT, exp_r.y);
            chk("model_flags", {N, Z, V, C, DZ}, {exp_r.n, exp_r.z, exp_r.v, exp_r.c, exp_r.dz});
        end
    end
    task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        @(posedge clk); #2;
        op = o; A = a; B = b; start = 1;
    endtask
    task automatic wait_done(output int s);
        bit got = 0;
        s = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else if (STALL) s++;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask
    task automatic run(logic [1:0] o, logic [31:0] a, logic [31:0] b, output int s);
        issue(o, a, b);
        wait_done(s);
        @(posedge clk); #2;
        start = 0;
    endtask
    logic [1:0]  t_op [7] = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [31:0] t_a  [7] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'h12345678, 32'h7FFFFFFF, 32'hFFFFFFF9};
    logic [31:0] t_b  [7] = '{32'hFFFFFFFE, 32'd7, 32'h80000000, 32'd0, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'hFFFFFFFE};
    initial begin
        R = 1; start = 0; kill = 0; op = 0; A = 0; B = 0;
        repeat (2) @(posedge clk);
        #2 R = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", STALL, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_y", Y_OUT, 0);
        chk("rst_flags", {N, Z, V, C, DZ}, 0);
        run(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, st);
        chk("umul_res", RESULT, 32'h00000001);
        chk("umul_y", Y_OUT, 32'hFFFFFFFE);
        chk("umul_flags", {N, Z, V, C, DZ}, 5'b00000);
        chk("umul_stall", st, 35);
        @(negedge clk);
        chk("umul_single_pulse", done, 0);
        run(2'd1, 32'hFFFFFFFD, 32'd7, st);
        chk("smul_res", RESULT, 32'hFFFFFFEB);
        chk("smul_y", Y_OUT, 32'hFFFFFFFF);
        chk("smul_nz", {N, Z}, 2'b10);
        run(2'd3, 32'hFFFFFFF9, 32'd2, st);
        chk("sdiv_res", RESULT, 32'hFFFFFFFD);
        chk("sdiv_y", Y_OUT, 32'hFFFFFFFF);
        run(2'd3, 32'h80000000, 32'hFFFFFFFF, st);
        chk("sdiv_ovf_res", RESULT, 32'h7FFFFFFF);
        chk("sdiv_ovf_y", Y_OUT, 0);
        chk("sdiv_ovf_v", V, 1);
        run(2'd2, 32'd100, 32'd0, st);
        chk("dz_flag", DZ, 1);
        chk("dz_res", RESULT, 32'hFFFFFFFF);
        chk("dz_y", Y_OUT, 32'h64);
        chk("dz_v", V, 1);
        chk("dz_stall", st, 2);
        issue(2'd2, 32'd0, 32'd5);
        wait_done(st);
        chk("udiv0_res", RESULT, 0);
        chk("udiv0_z", Z, 1);
        chk("udiv0_y", Y_OUT, 0);
        op = 2'd0; A = 32'd3; B = 32'd4;
        wait_done(st);
        chk("held_start_stall", st, 35);
        chk("held_start_res", RESULT, 32'd12);
        @(posedge clk); #2;
        start = 0;
        issue(2'd0, 32'h1234, 32'h5678);
        repeat (12) @(posedge clk);
        #2 kill = 1; start = 0;
        @(posedge clk); #2;
        chk("kill_busy", busy, 0);
        chk("kill_stall", STALL, 0);
        kill = 0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("kill_no_done", cnt, 0);
        chk("kill_result_held", RESULT, 32'd12);
        issue(2'd0, 32'h1234, 32'h5678);
        repeat (22) @(posedge clk);
        #2 R = 1; start = 0;
        @(posedge clk); #2;
        R = 0;
        chk("rstrun_busy", busy, 0);
        chk("rstrun_stall", STALL, 0);
        chk("rstrun_done", done, 0);
        chk("rstrun_result", RESULT, 0);
        chk("rstrun_y", Y_OUT, 0);
        chk("rstrun_flags", {N, Z, V, C, DZ}, 0);
        run(2'd0, 32'd6, 32'd7, st);
        chk("umul_6x7", RESULT, 32'd42);
        for (int k = 0; k < 7; k++) begin
            issue(t_op[k], t_a[k], t_b[k]);
            @(posedge clk); #2;
            A = ~A; B = ~B;
            wait_done(st);
            @(posedge clk); #2;
            start = 0;
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
